ud_counter_bank: RTL and testbench

- Multi-channel, parametrised up/down counter bank; next generation of the team's 4-bit saturating up/down counter.
- Adds configurable width, channel count and step size.
- Adds programmable lower/upper limits, saturate-or-wrap mode, synchronous load, boundary flags, wrap pulses and sticky saturation flags.
- Used wherever several independent event tallies are needed: debounce scores, credit counts, level meters.

---
 rtl/ud_counter_bank_if.sv | 33 +++
 rtl/ud_counter_bank.sv | 122 ++++++++++++
 tb/tb_ud_counter_bank.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ud_counter_bank_if.sv
// Request/status bundle for ud_counter_bank.
// Master drives requests and limits; slave returns counts and flags.
interface ud_counter_bank_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
);
    logic [CHANNELS-1:0]       count_en;
    logic [CHANNELS-1:0]       count_up1_dwn0;
    logic                      wrap_mode;
    logic [CHANNELS-1:0]       load_en;
    logic [WIDTH-1:0]          load_value;
    logic [WIDTH-1:0]          lim_lo;
    logic [WIDTH-1:0]          lim_hi;
    logic                      clear_flags;
    logic [CHANNELS*WIDTH-1:0] count;
    logic [CHANNELS-1:0]       at_hi;
    logic [CHANNELS-1:0]       at_lo;
    logic [CHANNELS-1:0]       wrap_evt;
    logic [CHANNELS-1:0]       sat_sticky;
    logic                      cfg_err;

    modport master (
        output count_en, count_up1_dwn0, wrap_mode, load_en,
        output load_value, lim_lo, lim_hi, clear_flags,
        input  count, at_hi, at_lo, wrap_evt, sat_sticky, cfg_err
    );

    modport slave (
        input  count_en, count_up1_dwn0, wrap_mode, load_en,
        input  load_value, lim_lo, lim_hi, clear_flags,
        output count, at_hi, at_lo, wrap_evt, sat_sticky, cfg_err
    );
endinterface

// File: rtl/ud_counter_bank.sv
// Bank of independent up/down counters with programmable limits,
// saturate-or-wrap rollover, clamped load and sticky saturation flags.
module ud_counter_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int STEP     = 1
) (
    input logic            clk,
    input logic            reset,
    ud_counter_bank_if.slave bus
);
    localparam int W1 = WIDTH + 1;
    localparam logic [W1-1:0]    STEP_X = W1'(STEP);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [W1-1:0]             lo_x;
    logic [W1-1:0]             hi_x;
    logic                      cfg_err;
    logic [WIDTH-1:0]          load_clamped;
    logic [CHANNELS*WIDTH-1:0] count_vec;
    logic [CHANNELS-1:0]       at_hi_vec;
    logic [CHANNELS-1:0]       at_lo_vec;
    logic [CHANNELS-1:0]       wrap_vec;
    logic [CHANNELS-1:0]       sat_vec;

    assign lo_x    = {1'b0, bus.lim_lo};
    assign hi_x    = {1'b0, bus.lim_hi};
    assign cfg_err = bus.lim_lo > bus.lim_hi;

    // Only meaningful when the limits are consistent; cfg_err blocks loads.
    always_comb begin
        load_clamped = bus.load_value;
        if (bus.load_value < bus.lim_lo)
            load_clamped = bus.lim_lo;
        else if (bus.load_value > bus.lim_hi)
            load_clamped = bus.lim_hi;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] cnt_d;
        logic             wrap_q;
        logic             wrap_d;
        logic             sat_q;
        logic             sat_d;
        logic             sat_set;
        logic [W1-1:0]    cnt_x;
        logic [W1-1:0]    up_room;
        logic [W1-1:0]    dn_room;

        assign cnt_x = {1'b0, cnt_q};

        // Headroom is zero when the count already sits beyond the limit.
        always_comb begin
            up_room = '0;
            dn_room = '0;
            if (cnt_x <= hi_x)
                up_room = hi_x - cnt_x;
            if (cnt_x >= lo_x)
                dn_room = cnt_x - lo_x;
        end

        always_comb begin
            cnt_d   = cnt_q;
            wrap_d  = 1'b0;
            sat_set = 1'b0;
            if (cfg_err) begin
                cnt_d = cnt_q;
            end else if (bus.load_en[i]) begin
                cnt_d = load_clamped;
            end else if (bus.count_en[i]) begin
                if (bus.count_up1_dwn0[i]) begin
                    if (up_room >= STEP_X) begin
                        cnt_d = cnt_q + STEP_W;
                    end else if (bus.wrap_mode) begin
                        cnt_d  = bus.lim_lo;
                        wrap_d = 1'b1;
                    end else begin
                        cnt_d   = bus.lim_hi;
                        sat_set = 1'b1;
                    end
                end else begin
                    if (dn_room >= STEP_X) begin
                        cnt_d = cnt_q - STEP_W;
                    end else if (bus.wrap_mode) begin
                        cnt_d  = bus.lim_hi;
                        wrap_d = 1'b1;
                    end else begin
                        cnt_d   = bus.lim_lo;
                        sat_set = 1'b1;
                    end
                end
            end
            sat_d = sat_set | (sat_q & ~bus.clear_flags);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q  <= '0;
                wrap_q <= 1'b0;
                sat_q  <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                wrap_q <= wrap_d;
                sat_q  <= sat_d;
            end
        end

        assign count_vec[i*WIDTH +: WIDTH] = cnt_q;
        assign at_hi_vec[i] = cnt_q == bus.lim_hi;
        assign at_lo_vec[i] = cnt_q == bus.lim_lo;
        assign wrap_vec[i]  = wrap_q;
        assign sat_vec[i]   = sat_q;
    end

    assign bus.count      = count_vec;
    assign bus.at_hi      = at_hi_vec;
    assign bus.at_lo      = at_lo_vec;
    assign bus.wrap_evt   = wrap_vec;
    assign bus.sat_sticky = sat_vec;
    assign bus.cfg_err    = cfg_err;
endmodule

// File: tb/tb_ud_counter_bank.sv
// Scoreboard bench for ud_counter_bank: directed scenarios plus random
// traffic, checked against an integer-arithmetic reference model.
module tb_ud_counter_bank;
    localparam int CH   = 4;
    localparam int W    = 8;
    localparam int STEP = 3;

    typedef struct packed {
        logic [CH*W-1:0] cnt;
        logic [CH-1:0]   wev;
        logic [CH-1:0]   sat;
        logic [CH-1:0]   ahi;
        logic [CH-1:0]   alo;
        logic            cfg;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    int m_cnt [CH];
    bit m_sat [CH];

    ud_counter_bank_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

    ud_counter_bank #(.CHANNELS(CH), .WIDTH(W), .STEP(STEP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: each rule applied directly with signed integer headroom.
    task automatic drive(input bit rst, input logic [CH-1:0] en,
                         input logic [CH-1:0] dir, input logic [CH-1:0] ld,
                         input int lv, input int lo, input int hi,
                         input bit wm, input bit clr);
        exp_t e;
        @(negedge clk);
        reset              = rst;
        bus.count_en       = en;
        bus.count_up1_dwn0 = dir;
        bus.load_en        = ld;
        bus.load_value     = W'(lv);
        bus.lim_lo         = W'(lo);
        bus.lim_hi         = W'(hi);
        bus.wrap_mode      = wm;
        bus.clear_flags    = clr;
        e = '0;
        for (int i = 0; i < CH; i++) begin
            bit set = 0;
            if (rst) begin
                m_cnt[i] = 0;
                m_sat[i] = 0;
            end else begin
                if (lo <= hi) begin
                    if (ld[i]) begin
                        m_cnt[i] = lv < lo ? lo : (lv > hi ? hi : lv);
                    end else if (en[i] && dir[i]) begin
                        if (hi - m_cnt[i] >= STEP) m_cnt[i] += STEP;
                        else if (wm) begin m_cnt[i] = lo; e.wev[i] = 1; end
                        else begin m_cnt[i] = hi; set = 1; end
                    end else if (en[i]) begin
                        if (m_cnt[i] - lo >= STEP) m_cnt[i] -= STEP;
                        else if (wm) begin m_cnt[i] = hi; e.wev[i] = 1; end
                        else begin m_cnt[i] = lo; set = 1; end
                    end
                end
                m_sat[i] = set || (m_sat[i] && !clr);
            end
            e.cnt[i*W +: W] = W'(m_cnt[i]);
            e.sat[i] = m_sat[i];
            e.ahi[i] = m_cnt[i] == hi;
            e.alo[i] = m_cnt[i] == lo;
        end
        e.cfg = lo > hi;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("count", 64'(bus.count), 64'(e.cnt));
                chk("wrap_evt", 64'(bus.wrap_evt), 64'(e.wev));
                chk("sat_sticky", 64'(bus.sat_sticky), 64'(e.sat));
                chk("at_hi", 64'(bus.at_hi), 64'(e.ahi));
                chk("at_lo", 64'(bus.at_lo), 64'(e.alo));
                chk("cfg_err", 64'(bus.cfg_err), 64'(e.cfg));
            end
        end
    end

    initial begin : stim
        int lo, hi, t;
        reset = 1'b1;
        bus.count_en = '0;
        bus.count_up1_dwn0 = '0;
        bus.load_en = '0;
        bus.load_value = '0;
        bus.lim_lo = '0;
        bus.lim_hi = '0;
        bus.wrap_mode = 1'b0;
        bus.clear_flags = 1'b0;
        repeat (2) drive(1, 0, 0, 0, 0, 0, 255, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 255, 0, 0);
        // ch0 climbs to 255 in steps of 3, then blocks and saturates
        repeat (90) drive(0, 4'b0001, 4'b0001, 0, 0, 0, 255, 0, 0);
        // wrap: 18 + 3 exceeds 20, rolls to 10, then 13
        drive(0, 0, 0, 4'b0010, 18, 10, 20, 1, 0);
        drive(0, 4'b0010, 4'b0010, 0, 0, 10, 20, 1, 0);
        drive(0, 4'b0010, 4'b0010, 0, 0, 10, 20, 1, 0);
        drive(0, 0, 0, 0, 0, 10, 20, 1, 0);
        // saturate low on ch2, sticky set-wins over clear
        drive(0, 0, 0, 4'b0100, 11, 10, 20, 0, 0);
        drive(0, 4'b0100, 0, 0, 0, 10, 20, 0, 0);
        drive(0, 4'b0100, 0, 0, 0, 10, 20, 0, 0);
        drive(0, 4'b0100, 0, 0, 0, 10, 20, 0, 1);
        drive(0, 0, 0, 0, 0, 10, 20, 0, 1);
        // clamped load and load-over-count
        drive(0, 0, 0, 4'b1000, 250, 0, 200, 0, 0);
        drive(0, 4'b1000, 4'b1000, 4'b1000, 5, 0, 200, 0, 0);
        // inconsistent limits freeze everything
        drive(0, 4'b1111, 4'b1010, 4'b0101, 45, 50, 40, 0, 0);
        drive(0, 4'b1111, 4'b0101, 0, 0, 50, 40, 1, 0);
        drive(0, 4'b1111, 4'b1111, 0, 0, 0, 200, 0, 0);
        // reset beats everything mid-operation
        drive(0, 4'b1111, 4'b1111, 0, 0, 0, 255, 0, 0);
        drive(1, 4'b1111, 4'b1111, 4'b1111, 77, 0, 255, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 255, 0, 0);
        lo = 0;
        hi = 255;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                lo = $urandom_range(0, 255);
                hi = $urandom_range(0, 255);
                if (lo > hi && $urandom_range(0, 7) != 0) begin
                    t = lo; lo = hi; hi = t;
                end
            end
            drive($urandom_range(0, 63) == 0,
                  4'($urandom), 4'($urandom),
                  4'($urandom & $urandom & $urandom),
                  $urandom_range(0, 255), lo, hi,
                  1'($urandom), $urandom_range(0, 7) == 0);
        end
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
